// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues one memory request at a time, buffers up to two
// {pc, instr} pairs for decode, and discards in-flight data when a jump flushes.
module if_fetch_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pc_in,
    output logic         pc_enable,
    input  logic         flush,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    output logic         id_valid,
    input  logic         id_ready,
    output logic [N-1:0] id_instr,
    output logic [N-1:0] id_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DROP = 2'b10
    } state_t;

    state_t       state_r;
    logic         imem_req_r;
    logic [N-1:0] imem_addr_r;
    logic [N-1:0] fifo_pc_r    [2];
    logic [N-1:0] fifo_instr_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   count_r;
    logic         push_s;
    logic         pop_s;
    logic         pc_enable_s;

    // Push/pop qualification and the PC-stage strobe
    always_comb begin
        push_s      = 1'b0;
        pop_s       = 1'b0;
        pc_enable_s = 1'b0;
        push_s = (state_r == REQ) && imem_ack && !flush;
        pop_s  = (count_r != 2'd0) && id_ready && !flush;
        if (rst) begin
            pc_enable_s = 1'b0;
        end else begin
            pc_enable_s = push_s || flush;
        end
    end

    // Request FSM; imem_req/imem_addr are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            imem_req_r  <= 1'b0;
            imem_addr_r <= {N{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    // Issue only with room for the reply, so the FIFO cannot overflow
                    if ((count_r <= 2'd1) && !flush) begin
                        state_r     <= REQ;
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= pc_in;
                    end else begin
                        state_r    <= IDLE;
                        imem_req_r <= 1'b0;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        state_r    <= IDLE;
                        imem_req_r <= 1'b0;
                    end else if (flush) begin
                        state_r    <= DROP;
                        imem_req_r <= 1'b1;
                    end else begin
                        state_r    <= REQ;
                        imem_req_r <= 1'b1;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state_r    <= IDLE;
                        imem_req_r <= 1'b0;
                    end else begin
                        state_r    <= DROP;
                        imem_req_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    imem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Two-entry FIFO of fetched {pc, instr}; flush empties it regardless of push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_pc_r[0]    <= {N{1'b0}};
            fifo_pc_r[1]    <= {N{1'b0}};
            fifo_instr_r[0] <= {N{1'b0}};
            fifo_instr_r[1] <= {N{1'b0}};
            wr_ptr_r        <= 1'b0;
            rd_ptr_r        <= 1'b0;
            count_r         <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_pc_r[wr_ptr_r]    <= imem_addr_r;
                fifo_instr_r[wr_ptr_r] <= imem_rdata;
                wr_ptr_r               <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign pc_enable = pc_enable_s;
    assign imem_req  = imem_req_r;
    assign imem_addr = imem_addr_r;
    assign id_valid  = (count_r != 2'd0);
    assign id_pc     = fifo_pc_r[rd_ptr_r];
    assign id_instr  = fifo_instr_r[rd_ptr_r];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: in-order fetch, backpressure, flush and reset cases.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_enable;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int   vec_count;
    int   err_count;
    int   popped;
    int   pulses;
    logic en;

    if_fetch_unit #(.N(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_enable  (pc_enable),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        if (obs !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        flush      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        id_ready   = 1'b0;
        pc_in      = 32'h0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        vec_count = 0;
        err_count = 0;

        // Reset values, with flush/ack high to show pc_enable is held low
        rst = 1'b1; flush = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        id_ready = 1'b1; pc_in = 32'h55;
        step();
        step();
        check_vec("rst_pc_enable", {31'd0, pc_enable}, 32'd0);
        check_vec("rst_imem_req",  {31'd0, imem_req},  32'd0);
        check_vec("rst_imem_addr", imem_addr, 32'h0);
        check_vec("rst_id_valid",  {31'd0, id_valid},  32'd0);
        check_vec("rst_id_instr",  id_instr, 32'h0);
        check_vec("rst_id_pc",     id_pc, 32'h0);

        // Zero-wait memory, decode always ready: pcs 0..3 arrive in order
        do_reset();
        id_ready = 1'b1;
        popped = 0;
        pulses = 0;
        for (int c = 0; c < 40 && popped < 4; c++) begin
            imem_ack   = imem_req;
            imem_rdata = instr_of(imem_addr);
            #1;
            if (pc_enable) pulses++;
            if (id_valid) begin
                check_vec("seq_pc", id_pc, 32'(popped));
                check_vec("seq_instr", id_instr, instr_of(32'(popped)));
                if (popped == 3) check_vec("seq_pulses", 32'(pulses), 32'd4);
                popped++;
            end
            en = pc_enable;
            step();
            if (en) pc_in = pc_in + 32'd1;
        end
        check_vec("seq_done", 32'(popped), 32'd4);

        // Backpressure with an always-acking memory: FIFO fills to two and stops
        do_reset();
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            imem_ack   = 1'b1;
            imem_rdata = instr_of(imem_addr);
            #1;
            if (pc_enable) pulses++;
            en = pc_enable;
            step();
            if (en) pc_in = pc_in + 32'd1;
        end
        imem_ack   = 1'b1;
        imem_rdata = instr_of(imem_addr);
        #1;
        check_vec("full_pulses",    32'(pulses), 32'd2);
        check_vec("full_imem_req",  {31'd0, imem_req},  32'd0);
        check_vec("full_pc_enable", {31'd0, pc_enable}, 32'd0);
        check_vec("full_valid",     {31'd0, id_valid},  32'd1);
        check_vec("full_head_pc",   id_pc, 32'h0);
        id_ready = 1'b1;
        #1;
        check_vec("drain0_instr", id_instr, instr_of(32'h0));
        step();
        check_vec("drain1_pc",    id_pc, 32'h1);
        check_vec("drain1_instr", id_instr, instr_of(32'h1));
        check_vec("drain1_valid", {31'd0, id_valid}, 32'd1);
        step();
        check_vec("drain_empty",  {31'd0, id_valid}, 32'd0);
        check_vec("refetch_req",  {31'd0, imem_req}, 32'd1);
        check_vec("refetch_addr", imem_addr, 32'h2);

        // Flush during REQ with a late ack: data dropped, jump target fetched next
        do_reset();
        id_ready = 1'b1;
        pc_in = 32'h10;
        step();
        check_vec("drop_req",  {31'd0, imem_req}, 32'd1);
        check_vec("drop_addr", imem_addr, 32'h10);
        flush = 1'b1;
        #1;
        check_vec("drop_flush_pc_enable", {31'd0, pc_enable}, 32'd1);
        step();
        flush = 1'b0;
        pc_in = 32'h40;
        #1;
        check_vec("drop_held_req",  {31'd0, imem_req}, 32'd1);
        check_vec("drop_held_addr", imem_addr, 32'h10);
        check_vec("drop_pc_enable", {31'd0, pc_enable}, 32'd0);
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check_vec("drop_ack_pc_enable", {31'd0, pc_enable}, 32'd0);
        step();
        imem_ack = 1'b0;
        check_vec("drop_discard_valid", {31'd0, id_valid}, 32'd0);
        check_vec("drop_idle_req",      {31'd0, imem_req}, 32'd0);
        step();
        check_vec("jump_req",   {31'd0, imem_req}, 32'd1);
        check_vec("jump_addr",  imem_addr, 32'h40);
        check_vec("jump_valid", {31'd0, id_valid}, 32'd0);

        // Flush coinciding with ack and pop: FIFO empties, nothing pushed
        do_reset();
        step();
        imem_ack   = 1'b1;
        imem_rdata = instr_of(32'h0);
        step();
        imem_ack = 1'b0;
        pc_in = 32'h1;
        step();
        check_vec("co_valid_before", {31'd0, id_valid}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = instr_of(32'h1);
        id_ready   = 1'b1;
        flush      = 1'b1;
        #1;
        check_vec("co_pc_enable", {31'd0, pc_enable}, 32'd1);
        step();
        flush    = 1'b0;
        imem_ack = 1'b0;
        pc_in    = 32'h80;
        #1;
        check_vec("co_empty",      {31'd0, id_valid},  32'd0);
        check_vec("co_idle_req",   {31'd0, imem_req},  32'd0);
        check_vec("co_pc_enable0", {31'd0, pc_enable}, 32'd0);
        step();
        check_vec("co_next_addr",  imem_addr, 32'h80);
        check_vec("co_still_empty", {31'd0, id_valid}, 32'd0);

        // Reset mid-request, then a stale ack: ignored, fetch restarts at 0
        do_reset();
        id_ready = 1'b1;
        pc_in = 32'h20;
        step();
        check_vec("mid_req", {31'd0, imem_req}, 32'd1);
        rst      = 1'b1;
        flush    = 1'b1;
        imem_ack = 1'b0;
        step();
        imem_ack = 1'b1;
        #1;
        check_vec("mid_rst_pc_enable", {31'd0, pc_enable}, 32'd0);
        check_vec("mid_rst_req",       {31'd0, imem_req},  32'd0);
        check_vec("mid_rst_addr",      imem_addr, 32'h0);
        check_vec("mid_rst_valid",     {31'd0, id_valid},  32'd0);
        rst   = 1'b0;
        flush = 1'b0;
        pc_in = 32'h0;
        imem_rdata = 32'hBAD0_BAD0;
        #1;
        check_vec("stale_ack_pc_enable", {31'd0, pc_enable}, 32'd0);
        step();
        imem_ack = 1'b0;
        check_vec("restart_req",   {31'd0, imem_req}, 32'd1);
        check_vec("restart_addr",  imem_addr, 32'h0);
        check_vec("restart_valid", {31'd0, id_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
